// File: rtl/imem_loader.sv
// Instruction memory with a UART byte-stream program loader.
// While the loader owns the memory, fetch sees NOPs and bytes are packed little-endian into words.
module imem_loader #(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [15:0]           PC,
    output logic [31:0]           instruction,
    output logic                  misaligned,
    input  logic                  load_mode,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [31:0]             shift_q, shift_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d, wr_addr_inc;
    logic [ADDR_WIDTH:0]     word_count_d;
    logic                    overflow_d;
    logic                    full;
    logic                    we;
    logic [31:0]             wdata;
    logic                    unused_pc;

    logic [31:0] mem [DEPTH];

    assign full        = (word_count == FULL_CNT);
    assign load_busy   = (state_q != IDLE);
    assign unused_pc   = ^PC;
    // wr_addr saturates at the top word instead of wrapping; the full flag gates writes.
    assign wr_addr_inc = (&wr_addr_q) ? wr_addr_q : wr_addr_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        wr_addr_d    = wr_addr_q;
        word_count_d = word_count;
        overflow_d   = overflow;
        we           = 1'b0;
        wdata        = '0;
        case (state_q)
            IDLE: begin
                if (load_mode) begin
                    state_d      = LOAD;
                    byte_cnt_d   = '0;
                    shift_d      = '0;
                    wr_addr_d    = '0;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                end
            end
            LOAD: begin
                if (rx_valid) begin
                    if (full) begin
                        overflow_d = 1'b1;
                    end else if (byte_cnt_q == 2'd3) begin
                        we           = 1'b1;
                        wdata        = {rx_data, shift_q[23:0]};
                        wr_addr_d    = wr_addr_inc;
                        word_count_d = word_count + (ADDR_WIDTH+1)'(1);
                        byte_cnt_d   = '0;
                        shift_d      = '0;
                    end else begin
                        shift_d[8*byte_cnt_q +: 8] = rx_data;
                        byte_cnt_d                 = byte_cnt_q + 2'd1;
                    end
                end
                // Exit decision sees the byte accepted in this same cycle.
                if (!load_mode)
                    state_d = (byte_cnt_d != 2'd0) ? FLUSH : DONE;
            end
            FLUSH: begin
                if (!full) begin
                    we           = 1'b1;
                    wdata        = shift_q;
                    wr_addr_d    = wr_addr_inc;
                    word_count_d = word_count + (ADDR_WIDTH+1)'(1);
                end
                byte_cnt_d = '0;
                shift_d    = '0;
                state_d    = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            wr_addr_q   <= '0;
            word_count  <= '0;
            overflow    <= 1'b0;
            load_done   <= 1'b0;
            instruction <= NOP_WORD;
            misaligned  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            wr_addr_q   <= wr_addr_d;
            word_count  <= word_count_d;
            overflow    <= overflow_d;
            load_done   <= (state_d == DONE);
            // Gated on the upcoming state so decode sees NOPs for the whole busy window.
            if (state_d == IDLE) begin
                instruction <= mem[PC[ADDR_WIDTH+1:2]];
                misaligned  <= (PC[1:0] != 2'b00);
            end else begin
                instruction <= NOP_WORD;
                misaligned  <= 1'b0;
            end
        end
    end

    // Contents survive reset, so the write port carries no reset.
    always_ff @(posedge clock) begin
        if (we)
            mem[wr_addr_q] <= wdata;
    end

endmodule
